uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

Receive-side counterpart of the UART transmit serializer. Recovers one UART frame (start, DATA_WIDTH data bits LSB first, optional parity, one stop bit) from the oversampled serial line RX_IN. It majority-votes three mid-bit samples per bit, deserializes the data into P_DATA, and flags parity and stop errors. It sits between the RX line synchronizer and the system-side register/FIFO logic.

## Interface
Parameters:
- DATA_WIDTH, 8, number of data bits per frame
- PRESCALE_WIDTH, 6, width of Prescale input

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- CLK  input  1  clock, running at Prescale × baud rate
- RST  input  1  synchronous reset, active-high
- RX_IN  input  1  serial line, already synchronized to CLK; idle high
- Prescale  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32
- PAR_EN  input  1  1 = parity bit present
- PAR_TYP  input  1  0 = even, 1 = odd
- P_DATA  output  DATA_WIDTH  received data, first received bit in P_DATA[0]; updated only with Data_Valid
- Data_Valid  output  1  one-cycle pulse, frame good
- Parity_Error  output  1  one-cycle pulse, parity mismatch
- Stop_Error  output  1  one-cycle pulse, stop bit sampled 0

## Operation
- Registers: FSM state, edge_cnt (PRESCALE_WIDTH bits), bit_cnt, 3 sample flops, shift register, a parity-fail flag, and latched Prescale/PAR_EN/PAR_TYP.
- States:
  - IDLE: RX_IN==0 → START. The detection cycle counts as edge 0, so edge_cnt=1 on the next cycle. Prescale, PAR_EN and PAR_TYP are latched here and held for the whole frame.
  - START, DATA, PARITY, STOP: edge_cnt counts 0..P-1 per bit, then wraps to 0.
- Sampling: RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1. The sampled bit is the majority of the three, valid from edge_cnt ≥ P/2+2.
- START: evaluated at edge P/2+2. Sampled 1 → glitch; go to IDLE with no outputs. Sampled 0 → continue. The state advances to DATA at edge P-1.
- DATA: at edge P-1, shift right with the sampled bit entering the MSB, and increment bit_cnt.
  - After DATA_WIDTH bits → PARITY if PAR_EN, else STOP.
- PARITY: at edge P-1, compare the sampled bit with the expected parity.
  - Even: expected bit = XOR of the data bits. Odd: its inverse.
  - On mismatch, pulse Parity_Error and set the fail flag.
  - The frame always proceeds to STOP.
- STOP: evaluated at edge P/2+2, then the FSM goes straight to IDLE. This leaves half a bit of margin for back-to-back frames.
  - Sampled 0 → pulse Stop_Error.
  - Sampled 1 and fail flag clear → load P_DATA and pulse Data_Valid.
  - Data_Valid is never asserted when either error occurred in the frame.
- Prescale values other than 8/16/32 are unsupported. The FSM must still complete each frame and return to IDLE; P_DATA content is then unspecified.
- RST: on the next edge, all outputs go to 0, the FSM goes to IDLE and all counters clear. A partial frame produces no pulse. RST has priority over everything.

## Timing
- Reset values: P_DATA=0, Data_Valid=0, Parity_Error=0, Stop_Error=0.
- All outputs are registered. Each pulse appears the cycle after the evaluation edge.
- Let T0 be the IDLE cycle in which RX_IN==0 is first seen, P = Prescale and N = DATA_WIDTH.
  - Bit k (start = 0) occupies cycles T0+kP .. T0+kP+P-1.
  - Data_Valid / Stop_Error appear at T0+(N+1+PAR_EN)·P + P/2 + 3.
  - Parity_Error appears at T0+(N+2)·P.
- P=8, N=8 examples:
  - Data_Valid at T0+79 without parity, T0+87 with parity.
  - Parity_Error at T0+80.
- RX_IN going low in IDLE immediately after the stop evaluation starts a new frame with no dead cycles.
- P_DATA holds its value until the next Data_Valid.

## Test plan
- P=8, PAR_EN=0, frame 0xA5, stop=1 → Data_Valid pulse at T0+79, P_DATA=0xA5, no error pulses.
- P=16, PAR_EN=1, PAR_TYP=0, frame 0x3C with parity bit 0 → Data_Valid at T0+171, P_DATA=0x3C, Parity_Error stays 0.
- P=8, PAR_EN=1, PAR_TYP=1, frame 0x01 with parity bit 1 (wrong) → Parity_Error pulse at T0+80, no Data_Valid, P_DATA unchanged.
- P=8, PAR_EN=0, frame 0x55 with stop bit 0 → Stop_Error at T0+79, no Data_Valid; the next valid frame 0x0F is received correctly.
- P=8, RX_IN low for only 2 cycles (glitch) → FSM back in IDLE after edge 6, no pulses. Separately, a 0xAA frame with one corrupted sample per bit (e.g. edge P/2 inverted) is still received as 0xAA.
- RST asserted mid-DATA → next cycle all outputs 0 and FSM in IDLE, no pulse for the partial frame. Also two back-to-back frames 0x12, 0x34 → two Data_Valid pulses exactly 10·P cycles apart.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
// Receives one UART frame (start, DATA_WIDTH data bits LSB first, optional
// parity, one stop bit) from an oversampled, already-synchronized RX line.
// Every bit is sampled three times around its middle and majority-voted.
//
// Ports:
//   CLK          clock, Prescale x baud rate
//   RST          synchronous reset, active-high
//   RX_IN        serial line, idle high
//   Prescale     oversampling ratio (8, 16 or 32)
//   PAR_EN       1 = frame carries a parity bit
//   PAR_TYP      0 = even parity, 1 = odd parity
//   P_DATA       last good frame's data, first received bit in P_DATA[0]
//   Data_Valid   one-cycle pulse, frame received without error
//   Parity_Error one-cycle pulse, parity mismatch
//   Stop_Error   one-cycle pulse, stop bit sampled low
// ---------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      Parity_Error,
    output logic                      Stop_Error
);

    localparam int PW = PRESCALE_WIDTH;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW-1:0] TWO      = PW'(2);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state_q,   state_d;
    logic [PW-1:0]           edge_q,    edge_d;
    logic [BW-1:0]           bit_q,     bit_d;
    logic [2:0]              smp_q,     smp_d;
    logic [DATA_WIDTH-1:0]   shreg_q,   shreg_d;
    logic                    pfail_q,   pfail_d;
    logic [PW-1:0]           presc_q,   presc_d;
    logic                    par_en_q,  par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0]   pdata_q,   pdata_d;
    logic                    dv_q,      dv_d;
    logic                    pe_q,      pe_d;
    logic                    se_q,      se_d;

    logic [PW-1:0] half;
    logic          last_edge;
    logic          eval_edge;
    logic          maj;
    logic          par_exp;

    assign half      = presc_q >> 1;
    assign last_edge = (edge_q == (presc_q - ONE));
    assign eval_edge = (edge_q == (half + TWO));
    assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign par_exp   = (^shreg_q) ^ par_typ_q;

    always_comb begin
        state_d   = state_q;
        edge_d    = last_edge ? '0 : edge_q + ONE;
        bit_d     = bit_q;
        smp_d     = smp_q;
        shreg_d   = shreg_q;
        pfail_d   = pfail_q;
        presc_d   = presc_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;

        if (edge_q == (half - ONE)) smp_d[0] = RX_IN;
        if (edge_q == half)         smp_d[1] = RX_IN;
        if (edge_q == (half + ONE)) smp_d[2] = RX_IN;

        case (state_q)
            S_IDLE: begin
                presc_d   = Prescale;
                par_en_d  = PAR_EN;
                par_typ_d = PAR_TYP;
                edge_d    = '0;
                bit_d     = '0;
                pfail_d   = 1'b0;
                if (!RX_IN) begin
                    // The detection cycle is edge 0 of the start bit.
                    state_d = S_START;
                    edge_d  = ONE;
                end
            end
            S_START: begin
                if (eval_edge && maj) begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                end else if (last_edge) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (last_edge) begin
                    shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (last_edge) begin
                    if (maj != par_exp) begin
                        pe_d    = 1'b1;
                        pfail_d = 1'b1;
                    end
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // The last-edge term only matters for unsupported Prescale
                // values whose evaluation edge is never reached; it keeps the
                // FSM from stalling in STOP.
                if (eval_edge || last_edge) begin
                    state_d = S_IDLE;
                    edge_d  = '0;
                    if (!maj) begin
                        se_d = 1'b1;
                    end else if (!pfail_q) begin
                        pdata_d = shreg_q;
                        dv_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                edge_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            smp_q     <= '0;
            shreg_q   <= '0;
            pfail_q   <= 1'b0;
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            smp_q     <= smp_d;
            shreg_q   <= shreg_d;
            pfail_q   <= pfail_d;
            presc_q   <= presc_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end

    assign P_DATA       = pdata_q;
    assign Data_Valid   = dv_q;
    assign Parity_Error = pe_q;
    assign Stop_Error   = se_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deserializer
// Directed bench: a table of complete frames with hand-computed pulse
// timing and data, followed by glitch, reset-mid-frame and back-to-back
// sequences. Pulse cycles are measured relative to T0, the first cycle in
// which the line is driven low for a frame.
// ---------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Parity_Error;
    logic       Stop_Error;

    uart_rx_deserializer #(
        .DATA_WIDTH    (8),
        .PRESCALE_WIDTH(6)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .P_DATA      (P_DATA),
        .Data_Valid  (Data_Valid),
        .Parity_Error(Parity_Error),
        .Stop_Error  (Stop_Error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Pulse monitor: absolute cycle of every pulse, plus P_DATA at each Data_Valid.
    int         dv_q[$];
    logic [7:0] dvd_q[$];
    int         pe_q[$];
    int         se_q[$];

    always @(negedge CLK) begin
        if (Data_Valid === 1'b1) begin
            dv_q.push_back(cyc);
            dvd_q.push_back(P_DATA);
        end
        if (Parity_Error === 1'b1) pe_q.push_back(cyc);
        if (Stop_Error === 1'b1)   se_q.push_back(cyc);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int t0      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_mon();
        dv_q.delete();
        dvd_q.delete();
        pe_q.delete();
        se_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
            RX_IN = 1'b1;
        end
    endtask

    // Drives one frame; configuration is applied in cycle T0 alongside the start bit.
    task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                              input bit par_bad, input bit stop, input bit corrupt);
        logic [10:0] bits;
        int          nb;
        logic        v;
        nb      = pen ? 11 : 10;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        if (pen) bits[9] = (^d) ^ ptyp ^ par_bad;
        bits[nb-1] = stop;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < p; j++) begin
                @(posedge CLK);
                #1;
                v = bits[b];
                if (corrupt && j == p / 2) v = ~v;
                RX_IN = v;
                if (b == 0 && j == 0) begin
                    t0       = cyc;
                    Prescale = 6'(p);
                    PAR_EN   = pen;
                    PAR_TYP  = ptyp;
                end
            end
        end
    endtask

    typedef struct {
        int         p;
        bit         pen;
        bit         ptyp;
        logic [7:0] data;
        bit         par_bad;
        bit         stop;
        bit         corrupt;
        int         edv;
        int         epe;
        int         ese;
        int         dv_at;
        int         pe_at;
        int         se_at;
        logic [7:0] epd;
    } vec_t;

    vec_t vecs[9];

    int first_dv;
    int first_pe;
    int first_se;

    initial begin
        //           p  pen ptyp data   pbad stop corr dv pe se dv_at pe_at se_at pdata
        vecs[0] = '{ 8, 0,  0,   8'hA5, 0,   1,   0,   1, 0, 0, 79,   0,    0,    8'hA5};
        vecs[1] = '{16, 1,  0,   8'h3C, 0,   1,   0,   1, 0, 0, 171,  0,    0,    8'h3C};
        vecs[2] = '{ 8, 1,  1,   8'h01, 1,   1,   0,   0, 1, 0, 0,    80,   0,    8'h3C};
        vecs[3] = '{ 8, 0,  0,   8'h55, 0,   0,   0,   0, 0, 1, 0,    0,    79,   8'h3C};
        vecs[4] = '{ 8, 0,  0,   8'h0F, 0,   1,   0,   1, 0, 0, 79,   0,    0,    8'h0F};
        vecs[5] = '{ 8, 0,  0,   8'hAA, 0,   1,   1,   1, 0, 0, 79,   0,    0,    8'hAA};
        vecs[6] = '{32, 1,  1,   8'h96, 0,   1,   0,   1, 0, 0, 339,  0,    0,    8'h96};
        vecs[7] = '{16, 0,  0,   8'hFF, 0,   1,   0,   1, 0, 0, 155,  0,    0,    8'hFF};
        vecs[8] = '{ 8, 1,  0,   8'h07, 1,   0,   0,   0, 1, 1, 0,    80,   87,   8'hFF};

        RST      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset P_DATA",       int'(P_DATA),       0);
        chk("reset Data_Valid",   int'(Data_Valid),   0);
        chk("reset Parity_Error", int'(Parity_Error), 0);
        chk("reset Stop_Error",   int'(Stop_Error),   0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(4);

        for (int i = 0; i < 9; i++) begin
            clear_mon();
            send_frame(vecs[i].p, vecs[i].pen, vecs[i].ptyp, vecs[i].data,
                       vecs[i].par_bad, vecs[i].stop, vecs[i].corrupt);
            idle(2 * vecs[i].p);
            first_dv = (dv_q.size() > 0) ? dv_q[0] - t0 : -1;
            first_pe = (pe_q.size() > 0) ? pe_q[0] - t0 : -1;
            first_se = (se_q.size() > 0) ? se_q[0] - t0 : -1;
            chk($sformatf("vec%0d dv_count", i), dv_q.size(), vecs[i].edv);
            chk($sformatf("vec%0d pe_count", i), pe_q.size(), vecs[i].epe);
            chk($sformatf("vec%0d se_count", i), se_q.size(), vecs[i].ese);
            if (vecs[i].edv > 0) chk($sformatf("vec%0d dv_cycle", i), first_dv, vecs[i].dv_at);
            if (vecs[i].epe > 0) chk($sformatf("vec%0d pe_cycle", i), first_pe, vecs[i].pe_at);
            if (vecs[i].ese > 0) chk($sformatf("vec%0d se_cycle", i), first_se, vecs[i].se_at);
            chk($sformatf("vec%0d P_DATA", i), int'(P_DATA), int'(vecs[i].epd));
        end

        // Two-cycle glitch, then a real frame starting right after the glitch
        // is rejected at edge 6 (FSM back in IDLE from glitch T0+7).
        clear_mon();
        @(posedge CLK);
        #1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        @(posedge CLK);
        #1;
        RX_IN = 1'b0;
        idle(5);
        send_frame(8, 0, 0, 8'h5A, 0, 1, 0);
        idle(16);
        chk("glitch dv_count", dv_q.size(), 1);
        chk("glitch dv_cycle", (dv_q.size() > 0) ? dv_q[0] - t0 : -1, 79);
        chk("glitch P_DATA",   int'(P_DATA), 8'h5A);
        chk("glitch err_count", pe_q.size() + se_q.size(), 0);

        // Reset in the middle of the data bits of a 0xC3 frame.
        clear_mon();
        @(posedge CLK);
        #1;
        RX_IN = 1'b0;
        repeat (7) begin
            @(posedge CLK);
            #1;
            RX_IN = 1'b0;
        end
        repeat (8) begin
            @(posedge CLK);
            #1;
            RX_IN = 1'b1;
        end
        repeat (8) begin
            @(posedge CLK);
            #1;
            RX_IN = 1'b1;
        end
        repeat (4) begin
            @(posedge CLK);
            #1;
            RX_IN = 1'b0;
        end
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("midreset P_DATA",       int'(P_DATA),       0);
        chk("midreset Data_Valid",   int'(Data_Valid),   0);
        chk("midreset Parity_Error", int'(Parity_Error), 0);
        chk("midreset Stop_Error",   int'(Stop_Error),   0);
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        RX_IN = 1'b1;
        idle(100);
        chk("midreset pulse_count", dv_q.size() + pe_q.size() + se_q.size(), 0);
        send_frame(8, 0, 0, 8'h81, 0, 1, 0);
        idle(16);
        chk("postreset dv_cycle", (dv_q.size() > 0) ? dv_q[0] - t0 : -1, 79);
        chk("postreset P_DATA",   int'(P_DATA), 8'h81);

        // Back-to-back frames: no idle cycles between stop and next start.
        clear_mon();
        send_frame(8, 0, 0, 8'h12, 0, 1, 0);
        send_frame(8, 0, 0, 8'h34, 0, 1, 0);
        idle(16);
        chk("b2b dv_count", dv_q.size(), 2);
        chk("b2b spacing",  (dv_q.size() > 1) ? dv_q[1] - dv_q[0] : -1, 80);
        chk("b2b data0",    (dvd_q.size() > 0) ? int'(dvd_q[0]) : -1, 8'h12);
        chk("b2b data1",    (dvd_q.size() > 1) ? int'(dvd_q[1]) : -1, 8'h34);
        chk("b2b err_count", pe_q.size() + se_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
